// File: rtl/addr_seq_ctrl.sv
// Address sequencer: sweeps 0..N-1 over a ready/valid handshake, then pulses done_o.
// Optional abort input is compiled in with ADDR_SEQ_ABORT_EN.
module addr_seq_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ADDR_SEQ_ABORT_EN
  input  logic                  abort_i,
`endif
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] num_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // One extra bit so that a DEPTH of 2^ADDR_WIDTH still fits in the latched length.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [CW-1:0]         nlat_q, nlat_d;
  logic [CW-1:0]         num_ext;
  logic                  abort_w;
  logic                  last_w;
  logic                  hs_w;

`ifdef ADDR_SEQ_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign num_ext = {1'b0, num_i};
  assign last_w  = (state_q == RUN) && ({1'b0, cnt_q} == (nlat_q - CW'(1)));
  assign hs_w    = (state_q == RUN) && ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nlat_d  = nlat_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          nlat_d  = (num_ext > DEPTH_C) ? DEPTH_C : num_ext;
          state_d = (num_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort wins over a same-cycle handshake; the counter simply stops.
        if (abort_w) begin
          state_d = DONE;
        end else if (hs_w) begin
          if (last_w) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nlat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nlat_q  <= nlat_d;
    end
  end

  assign valid_o = (state_q == RUN);
  assign addr_o  = cnt_q;
  assign last_o  = last_w;
  assign busy_o  = (state_q == RUN) || (state_q == DONE);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl: vector table, hand-written corner cases,
// and randomized sweeps checked against an address-list reference model.
module tb_addr_seq_ctrl;

  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 100;
  localparam int LIMIT      = 1000;

  logic                  clk;
  logic                  rst_n;
  logic                  abort_i;
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] num_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  last_o;
  logic                  busy_o;
  logic                  done_o;

  int assertCount = 0;
  int failCount   = 0;

  addr_seq_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef ADDR_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i),
    .num_i  (num_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .addr_o (addr_o),
    .last_o (last_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int num;
    int expCount;
    int expLast;
    int expCycles;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input int num, input logic ready);
    start_i = start;
    num_i   = ADDR_WIDTH'(num);
    ready_i = ready;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, ".busy"},  32'(busy_o),  32'd0);
    checkOutput({tag, ".done"},  32'(done_o),  32'd0);
    checkOutput({tag, ".last"},  32'(last_o),  32'd0);
    checkOutput({tag, ".addr"},  32'(addr_o),  32'd0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
  // noise drives start_i/num_i while busy; those must be ignored.
  task automatic runSweep(input int num, input int mode, input bit noise,
                          output int hs, output int lastAddr, output int cyc);
    int  n;
    int  nxt;
    int  budget;
    logic rdy;
    n        = (num > DEPTH) ? DEPTH : num;
    nxt      = 0;
    hs       = 0;
    lastAddr = -1;
    cyc      = 0;
    budget   = 0;
    @(negedge clk);
    checkIdle("preIdle");
    applyStimulus(1'b1, num, 1'b0);
    @(negedge clk);
    cyc = 1;
    applyStimulus(1'b0, 0, 1'b0);
    while (valid_o === 1'b1 && budget < LIMIT) begin
      if (nxt >= n) begin
        checkOutput("overrun", 32'(nxt), 32'(n - 1));
        break;
      end
      checkOutput("sweep.busy", 32'(busy_o), 32'd1);
      checkOutput("sweep.done", 32'(done_o), 32'd0);
      checkOutput("sweep.addr", 32'(addr_o), 32'(nxt));
      checkOutput("sweep.last", 32'(last_o), 32'(nxt == n - 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (budget % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (noise) applyStimulus(budget[0], 9, rdy);
      else       applyStimulus(1'b0, num, rdy);
      if (rdy) begin
        hs++;
        if (last_o) lastAddr = int'(addr_o);
        nxt++;
      end
      budget++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("sweepLen", 32'(nxt), 32'(n));
    applyStimulus(1'b0, 0, 1'($urandom_range(0, 1)));
    checkOutput("doneCyc.done",  32'(done_o),  32'd1);
    checkOutput("doneCyc.valid", 32'(valid_o), 32'd0);
    checkOutput("doneCyc.busy",  32'(busy_o),  32'd1);
    budget = 0;
    while (busy_o === 1'b1 && budget < LIMIT) begin
      @(negedge clk);
      cyc++;
      budget++;
    end
    checkOutput("busyTimeout", 32'(budget < LIMIT), 32'd1);
    checkIdle("postIdle");
    ready_i = 1'b0;
  endtask

  initial begin
    int hs;
    int la;
    int cyc;
    int n;

    vecs[0] = '{num: 5,   expCount: 5,   expLast: 4,  expCycles: 7};
    vecs[1] = '{num: 0,   expCount: 0,   expLast: -1, expCycles: 2};
    vecs[2] = '{num: 1,   expCount: 1,   expLast: 0,  expCycles: 3};
    vecs[3] = '{num: 127, expCount: 100, expLast: 99, expCycles: 102};
    vecs[4] = '{num: 100, expCount: 100, expLast: 99, expCycles: 102};
    vecs[5] = '{num: 99,  expCount: 99,  expLast: 98, expCycles: 101};

    rst_n   = 1'b0;
    abort_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runSweep(vecs[i].num, 0, 1'b0, hs, la, cyc);
      checkOutput($sformatf("vec%0d.count", i),  32'(hs),  32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d.last", i),   32'(la),  32'(vecs[i].expLast));
      checkOutput($sformatf("vec%0d.cycles", i), 32'(cyc), 32'(vecs[i].expCycles));
    end

    $display("[TB] backpressure sweep");
    runSweep(4, 1, 1'b0, hs, la, cyc);
    checkOutput("bp.count", 32'(hs), 32'd4);
    checkOutput("bp.last",  32'(la), 32'd3);

    $display("[TB] start while busy");
    runSweep(3, 0, 1'b1, hs, la, cyc);
    checkOutput("busyStart.count", 32'(hs), 32'd3);
    checkOutput("busyStart.last",  32'(la), 32'd2);
    @(negedge clk);
    checkIdle("busyStart.idle");

    $display("[TB] reset mid-sweep");
    @(negedge clk);
    applyStimulus(1'b1, 6, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 6, 1'b1);
    checkOutput("rstMid.addr0", 32'(addr_o), 32'd0);
    @(negedge clk);
    checkOutput("rstMid.addr1", 32'(addr_o), 32'd1);
    @(negedge clk);
    checkOutput("rstMid.addr2", 32'(addr_o), 32'd2);
    rst_n = 1'b0;
    #1;
    checkIdle("rstMid.async");
    @(negedge clk);
    checkIdle("rstMid.held");
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checkIdle("rstMid.noDone");
    end
    runSweep(6, 0, 1'b0, hs, la, cyc);
    checkOutput("rstMid.restart", 32'(hs), 32'd6);

`ifdef ADDR_SEQ_ABORT_EN
    $display("[TB] abort sweep");
    @(negedge clk);
    applyStimulus(1'b1, 10, 1'b1);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      applyStimulus(1'b0, 10, 1'b1);
      checkOutput("abort.addr", 32'(addr_o), 32'(a));
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort.valid", 32'(valid_o), 32'd0);
    checkOutput("abort.done",  32'(done_o),  32'd1);
    @(negedge clk);
    checkOutput("abort.done2", 32'(done_o), 32'd0);
    checkOutput("abort.busy",  32'(busy_o), 32'd0);
    @(negedge clk);
    checkOutput("abort.idle", 32'(valid_o), 32'd0);
    ready_i = 1'b0;
`endif

    $display("[TB] randomized sweeps");
    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(0, 127));
      runSweep(n, 2, 1'(r % 2), hs, la, cyc);
      checkOutput("rand.count", 32'(hs), 32'((n > DEPTH) ? DEPTH : n));
      checkOutput("rand.last",  32'(la), 32'((n > DEPTH) ? DEPTH - 1 : n - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
